// File: rtl/dvp_pattern_tx.sv
// dvp_pattern_tx: DVP (vsync/href/RGB565 byte) transmitter driven by a built-in test pattern generator
module dvp_pattern_tx #(
    parameter int IMAGE_WIDTH  = 800,
    parameter int IMAGE_HEIGHT = 480,
    parameter int H_BLANK      = 64,
    parameter int VSYNC_LEN    = 2,
    parameter int V_BACK       = 4,
    parameter int V_FRONT      = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic        dvp_vsync,
    output logic        dvp_href,
    output logic [7:0]  dvp_data,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);
    localparam int LINE_CLKS = 2 * IMAGE_WIDTH + H_BLANK;
    localparam int LW        = $clog2(LINE_CLKS);
    localparam int XW        = $clog2(IMAGE_WIDTH);
    localparam int BAR_W     = IMAGE_WIDTH / 8;
    localparam int M1        = IMAGE_HEIGHT > VSYNC_LEN ? IMAGE_HEIGHT : VSYNC_LEN;
    localparam int M2        = V_BACK > V_FRONT ? V_BACK : V_FRONT;
    localparam int VMAX      = M1 > M2 ? M1 : M2;
    localparam int VW        = VMAX > 1 ? $clog2(VMAX) : 1;

    localparam logic [LW-1:0] LINE_LAST = LW'(LINE_CLKS - 1);
    localparam logic [LW-1:0] ACT_LAST  = LW'(2 * IMAGE_WIDTH - 1);
    localparam logic [VW-1:0] VS_LAST   = VW'(VSYNC_LEN - 1);
    localparam logic [VW-1:0] VB_LAST   = VW'(V_BACK - 1);
    localparam logic [VW-1:0] Y_LAST    = VW'(IMAGE_HEIGHT - 1);
    localparam logic [VW-1:0] VF_LAST   = VW'(V_FRONT - 1);

    // bar colours, bar 0 in the least significant slot
    localparam logic [127:0] BARS = {16'h0000, 16'h001F, 16'hF800, 16'hF81F,
                                     16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF};

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT} state_t;

    state_t        state, state_n;
    logic [LW-1:0] lcnt, lcnt_n;
    logic [VW-1:0] vcnt, vcnt_n;
    logic [1:0]    sel_r, sel_n;
    logic [7:0]    fid_r, fid_n;
    logic          start, line_end, done_n;
    logic [XW-1:0] x_n;
    logic [2:0]    bar_n;
    logic          chk_n;
    logic [15:0]   pix_n;
    logic [7:0]    byte_n;

    // next-state, counters and the pixel byte for the next cycle; outputs register these
    always_comb begin
        state_n  = state;
        lcnt_n   = lcnt;
        vcnt_n   = vcnt;
        start    = 1'b0;
        line_end = lcnt == LINE_LAST;
        if (state != IDLE)
            lcnt_n = line_end ? '0 : lcnt + 1'b1;
        case (state)
            IDLE: begin
                start   = enable;
                state_n = enable ? VSYNC : IDLE;
                lcnt_n  = '0;
                vcnt_n  = '0;
            end
            VSYNC: if (line_end) begin
                state_n = vcnt == VS_LAST ? VBACK : VSYNC;
                vcnt_n  = vcnt == VS_LAST ? '0 : vcnt + 1'b1;
            end
            VBACK: if (line_end) begin
                state_n = vcnt == VB_LAST ? ACTIVE : VBACK;
                vcnt_n  = vcnt == VB_LAST ? '0 : vcnt + 1'b1;
            end
            ACTIVE: state_n = lcnt == ACT_LAST ? HBLANK : ACTIVE;
            HBLANK: if (line_end) begin
                state_n = vcnt == Y_LAST ? VFRONT : ACTIVE;
                vcnt_n  = vcnt == Y_LAST ? '0 : vcnt + 1'b1;
            end
            VFRONT: if (line_end) begin
                start   = vcnt == VF_LAST && enable;
                state_n = vcnt != VF_LAST ? VFRONT : enable ? VSYNC : IDLE;
                vcnt_n  = vcnt == VF_LAST ? '0 : vcnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
        done_n = state_n == VFRONT && lcnt_n == LINE_LAST && vcnt_n == VF_LAST;
        sel_n  = start ? pattern_sel : sel_r;
        fid_n  = start ? frame_cnt[7:0] : fid_r;
        x_n    = lcnt_n[XW:1];
        bar_n  = 3'(x_n / BAR_W);
        chk_n  = 1'((32'(x_n) >> 3) ^ (32'(vcnt_n) >> 3));
        pix_n  = sel_n == 2'd0 ? BARS[{bar_n, 4'b0000} +: 16] :
                 sel_n == 2'd1 ? 16'(x_n) :
                 sel_n == 2'd2 ? (chk_n ? 16'hFFFF : 16'h0000) : {fid_n, fid_n};
        byte_n = lcnt_n[0] ? pix_n[7:0] : pix_n[15:8];
    end

    // state, frame context and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            lcnt       <= '0;
            vcnt       <= '0;
            sel_r      <= '0;
            fid_r      <= '0;
            dvp_vsync  <= 1'b0;
            dvp_href   <= 1'b0;
            dvp_data   <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_n;
            lcnt       <= lcnt_n;
            vcnt       <= vcnt_n;
            sel_r      <= sel_n;
            fid_r      <= fid_n;
            dvp_vsync  <= state_n == VSYNC;
            dvp_href   <= state_n == ACTIVE;
            dvp_data   <= state_n == ACTIVE ? byte_n : 8'h00;
            busy       <= state_n != IDLE;
            frame_done <= done_n;
            frame_cnt  <= frame_cnt + 16'(done_n);
        end
    end
endmodule

// File: tb/tb_dvp_pattern_tx.sv
// tb_dvp_pattern_tx: per-cycle check of the DVP stream against a frame-timing reference model
module tb_dvp_pattern_tx;
    localparam int W  = 16;
    localparam int H  = 4;
    localparam int HB = 8;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int VF = 1;
    localparam int L  = 2 * W + HB;
    localparam int FR = (VS + VB + H + VF) * L;

    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic        dvp_vsync, dvp_href, busy, frame_done;
    logic [7:0]  dvp_data;
    logic [15:0] frame_cnt;
    logic [11:0] obs;
    int          checks = 0;
    int          errors = 0;
    int          cnt_m = 0;

    assign obs = {dvp_vsync, dvp_href, dvp_data, busy, frame_done};

    always #5 clk = ~clk;

    dvp_pattern_tx #(
        .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .H_BLANK(HB),
        .VSYNC_LEN(VS), .V_BACK(VB), .V_FRONT(VF)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pattern_sel(pattern_sel),
        .dvp_vsync(dvp_vsync), .dvp_href(dvp_href), .dvp_data(dvp_data),
        .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    function automatic logic [15:0] pixel(input logic [1:0] sel, input int x, input int y,
                                          input logic [7:0] fid);
        case (sel)
            2'd0:    return BARS[x / (W / 8)];
            2'd1:    return 16'(x);
            2'd2:    return (((x / 8) + (y / 8)) % 2) != 0 ? 16'hFFFF : 16'h0000;
            default: return {fid, fid};
        endcase
    endfunction

    // expected {vsync, href, data, busy, frame_done} at cycle t of a frame
    function automatic logic [11:0] model(input int t, input logic [1:0] sel, input logic [7:0] fid);
        int line, col;
        logic vs, hr;
        logic [15:0] p;
        logic [7:0] d;
        line = t / L;
        col  = t % L;
        vs   = line < VS;
        hr   = line >= VS + VB && line < VS + VB + H && col < 2 * W;
        p    = pixel(sel, col / 2, line - (VS + VB), fid);
        d    = !hr ? 8'h00 : (col % 2 == 0) ? p[15:8] : p[7:0];
        return {vs, hr, d, 1'b1, t == FR - 1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic run_frame(input logic [1:0] sel, input int n, input int drop_at);
        logic [7:0] fid;
        fid = 8'(cnt_m);
        for (int t = 0; t < n; t++) begin
            tick();
            check($sformatf("stream t=%0d sel=%0d", t, sel), 32'(obs), 32'(model(t, sel, fid)));
            if (t == FR - 1) begin
                cnt_m++;
                check("frame_cnt", 32'(frame_cnt), 32'(cnt_m & 16'hFFFF));
            end
            if (t == 100) pattern_sel = 2'($urandom);
            if (t == drop_at) enable = 1'b0;
        end
    endtask

    initial begin
        logic [1:0] s;
        repeat (3) tick();
        check("reset_outputs", 32'(obs), 32'd0);
        check("reset_frame_cnt", 32'(frame_cnt), 32'd0);
        reset_n = 1'b1;
        tick();
        check("idle_disabled", 32'(obs), 32'd0);
        for (int f = 0; f < 7; f++) begin
            s = f == 0 ? 2'd0 : f < 3 ? 2'd3 : 2'($urandom);
            pattern_sel = s;
            enable = 1'b1;
            run_frame(s, FR, f == 6 ? 5 * L + 10 : -1);
        end
        for (int i = 0; i < 50; i++) begin
            tick();
            check("idle_after_drop", 32'(obs), 32'd0);
        end
        check("frame_cnt_after_drop", 32'(frame_cnt), 32'd7);
        pattern_sel = 2'd1;
        enable = 1'b1;
        run_frame(2'd1, 150, -1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'(obs), 32'd0);
        check("async_reset_frame_cnt", 32'(frame_cnt), 32'd0);
        cnt_m = 0;
        tick();
        reset_n = 1'b1;
        pattern_sel = 2'd2;
        run_frame(2'd2, FR, 3);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_final", 32'(obs), 32'd0);
        end
        check("frame_cnt_final", 32'(frame_cnt), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
